// File: rtl/bram_row_loader_if.sv
// bram_row_loader_if: upstream beat stream plus BRAM port A write bus
interface bram_row_loader_if #(parameter int BEATS = 16);
    logic                  s_valid;
    logic                  s_ready;
    logic [63:0]           s_data;
    logic [3:0]            s_mode;
    logic                  cena;
    logic                  wea;
    logic [4:0]            addra;
    logic [BEATS*64+3:0]   dina;
    modport slave (input s_valid, s_data, s_mode, output s_ready, cena, wea, addra, dina);
    modport master (output s_valid, s_data, s_mode, input s_ready, cena, wea, addra, dina);
endinterface

// File: rtl/bram_row_loader.sv
// bram_row_loader: assembles 64-bit beats into rows, writes them to BRAM, then hands off to the sequencer
module bram_row_loader #(
    parameter int ROWS  = 12,
    parameter int BEATS = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_busy,
    output logic                o_start,
    output logic                o_busy,
    output logic                o_done,
    bram_row_loader_if.slave    bus
);
    localparam int W  = BEATS * 64 + 4;
    localparam int BW = $clog2(BEATS);
    typedef enum logic [2:0] {IDLE, FILL, WRITE, KICK, WAIT_BUSY, WAIT_DONE} state_t;
    state_t          state_q, state_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [4:0]      row_cnt_q, row_cnt_d, addra_q, addra_d;
    logic [W-1:0]    row_buf_q, row_buf_d;
    logic            cena_q, cena_d, start_q, start_d, done_q, done_d;
    logic            hs, last_beat;
    assign bus.s_ready = i_en && (state_q == IDLE || state_q == FILL);
    assign hs          = bus.s_valid && bus.s_ready;
    assign last_beat   = beat_cnt_q == BW'(BEATS - 1);
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        row_cnt_d  = row_cnt_q;
        row_buf_d  = row_buf_q;
        if (hs) begin
            row_buf_d[64*int'(beat_cnt_q) +: 64] = bus.s_data;
            if (beat_cnt_q == '0) row_buf_d[W-1 -: 4] = bus.s_mode;
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + BW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    row_cnt_d = '0;
                    state_d   = FILL;
                end
            end
            FILL:      state_d = (hs && last_beat) ? WRITE : FILL;
            WRITE: begin
                state_d   = (row_cnt_q == 5'(ROWS - 1)) ? KICK : FILL;
                row_cnt_d = (row_cnt_q == 5'(ROWS - 1)) ? row_cnt_q : row_cnt_q + 5'd1;
            end
            KICK:      state_d = WAIT_BUSY;
            WAIT_BUSY: state_d = i_busy ? WAIT_DONE : WAIT_BUSY;
            WAIT_DONE: state_d = i_busy ? WAIT_DONE : IDLE;
            default:   state_d = IDLE;
        endcase
        // port A is registered off the next state so it is live exactly while in WRITE
        cena_d  = state_d == WRITE;
        addra_d = (state_d == WRITE) ? row_cnt_q : addra_q;
        start_d = state_d == KICK;
        done_d  = state_q == WAIT_DONE && !i_busy;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            row_cnt_q  <= '0;
            row_buf_q  <= '0;
            addra_q    <= '0;
            cena_q     <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
        end else if (i_en) begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            row_cnt_q  <= row_cnt_d;
            row_buf_q  <= row_buf_d;
            addra_q    <= addra_d;
            cena_q     <= cena_d;
            start_q    <= start_d;
            done_q     <= done_d;
        end
    end
    assign bus.cena  = cena_q;
    assign bus.wea   = cena_q;
    assign bus.addra = addra_q;
    assign bus.dina  = row_buf_q;
    assign o_start   = start_q;
    assign o_done    = done_q;
    assign o_busy    = state_q != IDLE;
endmodule

// File: tb/tb_bram_row_loader.sv
// tb_bram_row_loader: randomized jobs checked against a row/beat array model of the loader
module tb_bram_row_loader;
    localparam int ROWS  = 12;
    localparam int BEATS = 16;
    localparam int TOTAL = ROWS * BEATS;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, busy = 1'b0;
    logic start, obusy, done;
    int   checks = 0, errors = 0;
    logic [63:0] beat_mem [ROWS][BEATS];
    logic [3:0]  mode_mem [ROWS];
    always #5 clk = ~clk;
    bram_row_loader_if #(.BEATS(BEATS)) bus ();
    bram_row_loader #(.ROWS(ROWS), .BEATS(BEATS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_busy(busy),
        .o_start(start), .o_busy(obusy), .o_done(done), .bus(bus)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic fill_job(input bit pattern);
        for (int r = 0; r < ROWS; r++) begin
            mode_mem[r] = pattern ? 4'hA : 4'($urandom);
            for (int k = 0; k < BEATS; k++)
                beat_mem[r][k] = pattern ? 64'h0101_0101_0101_0101 * 64'(k) : {$urandom, $urandom};
        end
    endtask
    task automatic check_zero_outputs(input string tag);
        chk({tag, "_cena"}, 64'(bus.cena), 0);
        chk({tag, "_wea"}, 64'(bus.wea), 0);
        chk({tag, "_addra"}, 64'(bus.addra), 0);
        chk({tag, "_start"}, 64'(start), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_busy"}, 64'(obusy), 0);
        chk({tag, "_dina"}, 64'(bus.dina == '0), 1);
    endtask
    task automatic run_job(input int gap_pct, input bit fill_stall, input bit kick_stall,
                           input bit busy_pre, input bit timing, input int abort_beats);
        int beats = 0, wr = 0, starts = 0, dones = 0, cyc = 0, first = -1, last_wr = -1;
        int busy_on = -1, busy_off = -1, busy_fall = -1, en_hold = 0, r;
        bit hs, fin = 0, fill_stalled = 0, start_seen = 0;
        busy = busy_pre;
        while (!fin && cyc < 4000) begin
            en = en_hold == 0;
            if (en_hold > 0) en_hold--;
            if (cyc == busy_on) busy = 1'b1;
            if (cyc == busy_off) begin
                busy = 1'b0;
                busy_fall = cyc;
            end
            r = (beats < TOTAL) ? beats / BEATS : 0;
            bus.s_valid = (beats < TOTAL) && ($urandom_range(99) >= gap_pct);
            bus.s_data  = beat_mem[r][beats % BEATS];
            bus.s_mode  = (beats % BEATS == 0) ? mode_mem[r] : 4'($urandom);
            #1;
            hs = bus.s_valid && bus.s_ready;
            if (!en) chk("ready_en_low", 64'(bus.s_ready), 0);
            if (en && start) begin
                starts++;
                busy_on  = busy_pre ? -1 : cyc + 2;
                busy_off = busy_pre ? cyc + 10 : cyc + 42;
            end
            @(posedge clk);
            #1;
            if (hs) begin
                beats++;
                if (first < 0) first = cyc;
            end
            if (bus.cena) begin
                chk("wea", 64'(bus.wea), 1);
                chk("addra", 64'(bus.addra), 64'(wr));
                chk("ready_in_write", 64'(bus.s_ready), 0);
                chk("busy_in_write", 64'(obusy), 1);
                if (wr < ROWS) begin
                    chk("dina_mode", 64'(bus.dina[BEATS*64 +: 4]), 64'(mode_mem[wr]));
                    for (int k = 0; k < BEATS; k++)
                        chk($sformatf("dina_r%0d_b%0d", wr, k), bus.dina[64*k +: 64], beat_mem[wr][k]);
                end
                if (timing) chk("write_time", 64'(cyc - first), 64'(15 + 17 * wr));
                last_wr = cyc;
                wr++;
            end
            if (start && !start_seen) begin
                start_seen = 1;
                chk("start_after_rows", 64'(wr), ROWS);
                if (timing) chk("start_latency", 64'(cyc - last_wr), 1);
                if (kick_stall) en_hold = 5;
            end
            if (fill_stall && !fill_stalled && beats == 40) begin
                fill_stalled = 1;
                en_hold = 5;
            end
            if (done) begin
                dones++;
                chk("done_after_busy_fall", 64'(cyc), 64'(busy_fall));
                fin = 1;
            end
            if (abort_beats > 0 && beats == abort_beats) begin
                bus.s_valid = 1'b0;
                #2;
                rst_n = 1'b0;
                #1;
                check_zero_outputs("reset_mid");
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            cyc++;
        end
        chk("job_timeout", 64'(fin), 1);
        chk("beats_taken", 64'(beats), TOTAL);
        chk("writes", 64'(wr), ROWS);
        chk("starts", 64'(starts), 1);
        chk("dones", 64'(dones), 1);
        bus.s_valid = 1'b0;
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("done_width", 64'(done), 0);
        chk("idle_busy", 64'(obusy), 0);
        chk("idle_no_write", 64'(bus.cena), 0);
    endtask
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_mode  = '0;
        #1;
        check_zero_outputs("reset");
        chk("reset_ready", 64'(bus.s_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_job(1);
        run_job(0, 0, 0, 0, 1, 0);
        fill_job(0);
        run_job(0, 0, 0, 0, 1, 0);
        run_job(50, 0, 0, 0, 0, 0);
        fill_job(0);
        run_job(0, 1, 1, 0, 0, 0);
        fill_job(0);
        run_job(30, 0, 0, 1, 0, 0);
        fill_job(0);
        run_job(0, 0, 0, 0, 0, 5 * BEATS + 8);
        fill_job(0);
        run_job(0, 0, 0, 0, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_row_loader.md
BRAM_ROW_LOADER -- requirements
Module: bram_row_loader

Interface
REQ-001 Parameter: ROWS, 12, number of BRAM rows loaded per job (addresses 0..ROWS-1).
REQ-002 Parameter: BEATS, 16, 64-bit beats per row (BEATS*64 = 1024 data bits).
REQ-003 i_clk  in  1  single clock; all logic rising-edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_en  in  1  global clock enable; when low, all registers hold.
REQ-006 i_s_valid  in  1  upstream beat valid.
REQ-007 o_s_ready  out  1  beat accepted when i_s_valid & o_s_ready.
REQ-008 i_s_data  in  64  beat payload.
REQ-009 i_s_mode  in  4  row length mode; sampled only on beat 0 of each row.
REQ-010 o_cena / o_wea  out  1 / 1  BRAM port A chip/write enable.
REQ-011 o_addra  out  5  BRAM port A address.
REQ-012 o_dina  out  1028  {mode[3:0], data[1023:0]} row written to BRAM.
REQ-013 o_start  out  1  one-cycle start pulse to the softmax BRAM sequencer.
REQ-014 i_busy  in  1  busy flag from the softmax BRAM sequencer.
REQ-015 o_busy  out  1  high in every state except IDLE.
REQ-016 o_done  out  1  one-cycle pulse when sequencer finishes the job.

Function
REQ-017 FSM states: IDLE, FILL, WRITE, KICK, WAIT_BUSY, WAIT_DONE.
REQ-018 o_s_ready SHALL equal i_en & (state==IDLE | state==FILL), combinational.
REQ-019 IDLE: on handshake, capture beat 0, beat_cnt<=1, row_cnt<=0, go FILL.
REQ-020 Beat k (0..15) SHALL be stored at row_buf[64k+63:64k]; i_s_mode captured into row_buf[1027:1024] at k=0.
REQ-021 FILL: each handshake stores beat, beat_cnt+1; handshake with beat_cnt==15 -> WRITE, beat_cnt<=0.
REQ-022 WRITE (one cycle): o_cena=o_wea=1, o_addra=row_cnt, o_dina=row_buf; no beat accepted.
REQ-023 After WRITE: row_cnt==ROWS-1 -> KICK; else row_cnt+1, -> FILL.
REQ-024 Port A outputs SHALL be registered; o_cena/o_wea high only in the cycle the FSM is in WRITE.
REQ-025 KICK: o_start=1 for exactly one enabled cycle, -> WAIT_BUSY.
REQ-026 WAIT_BUSY: stay until i_busy==1 (sampled), then -> WAIT_DONE; if i_busy already 1, leave next cycle.
REQ-027 WAIT_DONE: stay while i_busy==1; on i_busy==0, o_done=1 one cycle, -> IDLE.
REQ-028 Latency at full throughput: one row = 16 beat cycles + 1 write cycle; last write to o_start = 1 cycle.
REQ-029 Beats with i_s_valid low SHALL stall FILL without losing beat_cnt/row_buf.
REQ-030 i_s_valid during WRITE/KICK/WAIT_* SHALL not be accepted (ready low); data held upstream.
REQ-031 Loader SHALL never write addresses >= ROWS; addresses 12..23 belong to the sequencer result region.
REQ-032 i_en low: state, counters, registered outputs hold; o_s_ready low; no beat consumed.
REQ-033 row_cnt 5 bits, beat_cnt 4 bits; beat_cnt wraps 15->0 only via REQ-021.

Reset
REQ-034 i_rst_n low SHALL immediately force: state=IDLE, beat_cnt=0, row_cnt=0, row_buf=0, o_cena=0, o_wea=0, o_addra=0, o_start=0, o_done=0.
REQ-035 Reset mid-row or mid-job SHALL discard partial data; BRAM contents untouched; next job restarts at row 0.
REQ-036 Reset release is asynchronous-assert/synchronous-deassert at the top level; the block itself clears asynchronously.

Verification
REQ-037 Full job, valid always high, i_busy rises 2 cycles after o_start, low 40 cycles later -> 12 writes addr 0..11 every 17 cycles, one o_start, one o_done.
REQ-038 Row pattern: beat k = 64'h0101_0101_0101_0101*k, mode 4'hA -> o_dina[1027:1024]=4'hA, o_dina[64k+63:64k] matches each beat.
REQ-039 Random i_s_valid gaps (50%) -> identical BRAM contents as REQ-037, no lost/duplicate beats.
REQ-040 i_rst_n low at beat 7 of row 5 -> all outputs 0 within same cycle; new job writes from addr 0.
REQ-041 i_en low 5 cycles during FILL and during KICK -> ready low, o_start still exactly one enabled-cycle pulse, data intact.
REQ-042 i_busy held high before KICK -> WAIT_BUSY exits after one cycle; o_done only after i_busy falls.
